iob_pfsm_timed: RTL and testbench



---
 rtl/iob_pfsm_timed.sv | 161 ++++++++++++++++
 tb/tb_iob_pfsm_timed.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_pfsm_timed.sv
// Programmable LUT-driven FSM with optional per-transition dwell (IOB_PFSM_TIMED_DWELL_EN); one lookup per enabled edge in RUN.
// Outputs registered one edge after lookup; config writes accepted only while idle; cke_i low freezes everything.
module iob_pfsm_timed #(
    parameter int INPUT_W  = 1,
    parameter int STATE_W  = 2,
    parameter int OUTPUT_W = 1,
    parameter int DWELL_W  = 8,
    parameter int DATA_W   = 32,
`ifdef IOB_PFSM_TIMED_DWELL_EN
    localparam int FIELD_DW = DWELL_W,
`else
    // No dwell field in the LUT word.
    localparam int FIELD_DW = 0 * DWELL_W,
`endif
    localparam int LUT_W   = OUTPUT_W + STATE_W + FIELD_DW,
    localparam int N_WORDS = (LUT_W + DATA_W - 1) / DATA_W,
    localparam int SEL_W   = $clog2(N_WORDS) + 1,
    localparam int ADDR_W  = STATE_W + INPUT_W
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [INPUT_W-1:0]  input_ports_i,
    output logic [OUTPUT_W-1:0] output_ports_o,
    output logic [STATE_W-1:0]  state_o,
    output logic                running_o,
    input  logic                cfg_wen_i,
    input  logic [ADDR_W-1:0]   cfg_addr_i,
    input  logic [SEL_W-1:0]    cfg_sel_i,
    input  logic [DATA_W-1:0]   cfg_wdata_i,
    output logic                cfg_ready_o
);

    localparam int N_ENTRIES = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ctrl_e;

    ctrl_e               ctrl_q, ctrl_d;
    logic [STATE_W-1:0]  state_q, state_d;
    logic [OUTPUT_W-1:0] out_q, out_d;
    logic [LUT_W-1:0]    lut_q [N_ENTRIES];
    logic [LUT_W-1:0]    lut_d [N_ENTRIES];

    logic [LUT_W-1:0]    lut_rd;
    logic [OUTPUT_W-1:0] lut_out;
    logic [STATE_W-1:0]  lut_next;
    logic                wr_en;

`ifdef IOB_PFSM_TIMED_DWELL_EN
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [DWELL_W-1:0]  lut_dwell;
`endif

    assign lut_rd   = lut_q[{state_q, input_ports_i}];
    assign lut_out  = lut_rd[OUTPUT_W-1:0];
    assign lut_next = lut_rd[OUTPUT_W +: STATE_W];
`ifdef IOB_PFSM_TIMED_DWELL_EN
    assign lut_dwell = lut_rd[OUTPUT_W+STATE_W +: DWELL_W];
`endif

    assign output_ports_o = out_q;
    assign state_o        = state_q;
    assign wr_en          = cfg_wen_i && cfg_ready_o && (int'(cfg_sel_i) < N_WORDS);

    // State register: reset dominates, cke_i low holds every flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q  <= IDLE;
            state_q <= '0;
            out_q   <= '0;
            lut_q   <= '{default: '0};
`ifdef IOB_PFSM_TIMED_DWELL_EN
            cnt_q   <= '0;
`endif
        end else if (cke_i) begin
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
            out_q   <= out_d;
            lut_q   <= lut_d;
`ifdef IOB_PFSM_TIMED_DWELL_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Slice write: only the bits belonging to the selected DATA_W slice change.
    always_comb begin
        lut_d = lut_q;
        if (wr_en) begin
            for (int b = 0; b < LUT_W; b++) begin
                if ((b / DATA_W) == int'(cfg_sel_i)) begin
                    lut_d[cfg_addr_i][b] = cfg_wdata_i[b % DATA_W];
                end
            end
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        state_d = state_q;
        out_d   = out_q;
`ifdef IOB_PFSM_TIMED_DWELL_EN
        cnt_d   = cnt_q;
`endif
        case (ctrl_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    ctrl_d = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    ctrl_d  = IDLE;
                    state_d = '0;
                    out_d   = '0;
                end else begin
                    state_d = lut_next;
                    out_d   = lut_out;
`ifdef IOB_PFSM_TIMED_DWELL_EN
                    if (lut_dwell != '0) begin
                        cnt_d  = lut_dwell;
                        ctrl_d = HOLD;
                    end
`endif
                end
            end
`ifdef IOB_PFSM_TIMED_DWELL_EN
            HOLD: begin
                if (stop_i) begin
                    ctrl_d  = IDLE;
                    state_d = '0;
                    out_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                    if (cnt_q == DWELL_W'(1)) begin
                        ctrl_d = RUN;
                    end
                end
            end
`endif
            default: begin
                ctrl_d  = IDLE;
                state_d = '0;
                out_d   = '0;
            end
        endcase
    end

    always_comb begin
        running_o   = (ctrl_q != IDLE);
        cfg_ready_o = (ctrl_q == IDLE);
    end

endmodule

// File: tb/tb_iob_pfsm_timed.sv
// Bench for iob_pfsm_timed: directed steps plus a randomized phase checked against a cycle-level reference model.
module tb_iob_pfsm_timed;

    localparam int INPUT_W  = 1;
    localparam int STATE_W  = 2;
    localparam int OUTPUT_W = 1;
    localparam int DATA_W   = 32;
`ifdef IOB_PFSM_TIMED_DWELL_EN
    localparam int DW_EN = 1;
`else
    localparam int DW_EN = 0;
`endif
    localparam int LUT_W   = OUTPUT_W + STATE_W + (DW_EN != 0 ? 8 : 0);
    localparam int SEL_W   = 1;
    localparam int ADDR_W  = STATE_W + INPUT_W;
    localparam int N_ENT   = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                cke, rst, start, stop, cfg_wen;
    logic [INPUT_W-1:0]  in_p;
    logic [ADDR_W-1:0]   addr;
    logic [SEL_W-1:0]    sel;
    logic [DATA_W-1:0]   wdata;
    logic [OUTPUT_W-1:0] out_p;
    logic [STATE_W-1:0]  state;
    logic                running, ready;

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [31:0] m_lut [N_ENT];
    int          m_state, m_out, m_wait;
    bit          m_run;

    always #5 clk = ~clk;

    iob_pfsm_timed dut (
        .clk_i          (clk),
        .cke_i          (cke),
        .rst_i          (rst),
        .start_i        (start),
        .stop_i         (stop),
        .input_ports_i  (in_p),
        .output_ports_o (out_p),
        .state_o        (state),
        .running_o      (running),
        .cfg_wen_i      (cfg_wen),
        .cfg_addr_i     (addr),
        .cfg_sel_i      (sel),
        .cfg_wdata_i    (wdata),
        .cfg_ready_o    (ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One enabled edge = either a lookup or one cycle of remaining dwell.
    task automatic model_edge();
        logic [31:0] w;
        if (rst) begin
            for (int i = 0; i < N_ENT; i++) m_lut[i] = 32'd0;
            m_state = 0; m_out = 0; m_run = 0; m_wait = 0;
        end else if (cke) begin
            if (m_run) begin
                if (stop) begin
                    m_run = 0; m_state = 0; m_out = 0; m_wait = 0;
                end else if (m_wait > 0) begin
                    m_wait--;
                end else begin
                    w       = m_lut[m_state * (1 << INPUT_W) + int'(in_p)];
                    m_out   = int'(w % (1 << OUTPUT_W));
                    m_state = int'((w >> OUTPUT_W) % (1 << STATE_W));
                    m_wait  = (DW_EN != 0) ? int'((w >> (OUTPUT_W + STATE_W)) % 256) : 0;
                end
            end else begin
                if (cfg_wen && sel == 0) m_lut[addr] = wdata % (32'd1 << LUT_W);
                if (start && !stop) begin
                    m_run = 1; m_wait = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("out", 32'(out_p), 32'(m_out));
        chk("running", 32'(running), 32'(m_run));
        chk("cfg_ready", 32'(ready), 32'(!m_run));
    endtask

    task automatic wr(input int a, input int s, input logic [31:0] d);
        cfg_wen = 1'b1; addr = ADDR_W'(a); sel = SEL_W'(s); wdata = d;
        step();
        cfg_wen = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        int len;
        int k;
        cke = 1'b1; rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_wen = 1'b0;
        in_p = '0; addr = '0; sel = '0; wdata = '0;
        for (int i = 0; i < N_ENT; i++) m_lut[i] = 32'd0;
        m_state = 0; m_out = 0; m_run = 0; m_wait = 0;

        // Reset and idle behaviour, first lookup after start
        do_reset();
        chk("rst_ready", 32'(ready), 32'd1);
        wr(0, 0, 32'h5);
        step(); step();
        chk("idle_state", 32'(state), 32'd0);
        pulse_start();
        chk("start_running", 32'(running), 32'd1);
        step();
        chk("tp1_state", 32'(state), 32'd2);
        chk("tp1_out", 32'(out_p), 32'd1);
        step();
        pulse_stop();
        chk("stop_state", 32'(state), 32'd0);

        // 4-state ring counter; also a dropped out-of-range slice write
        do_reset();
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 2; i++)
                wr(s * 2 + i, 0, 32'(((s + 1) % 4) << OUTPUT_W | (s & 1)));
        wr(0, 1, 32'hFFFF_FFFF);
        start = 1'b1; stop = 1'b1;
        step();
        chk("start_stop_idle", 32'(running), 32'd0);
        stop = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_p = INPUT_W'($urandom);
            step();
            chk("ring_state", 32'(state), 32'((i + 1) % 4));
            chk("ring_out", 32'(out_p), 32'(i % 2));
        end
        wr(2, 0, 32'h0);
        wr(3, 0, 32'h0);
        for (int i = 0; i < 4; i++) step();
        chk("run_write_ignored", 32'(state), 32'd3);
        pulse_stop();

`ifdef IOB_PFSM_TIMED_DWELL_EN
        // Dwell: state 1 held 4 cycles, state 0 one cycle
        do_reset();
        wr(0, 0, 32'd26); wr(1, 0, 32'd26);
        wr(2, 0, 32'd1);  wr(3, 0, 32'd1);
        pulse_start();
        step();
        len = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (state == 2'd1) len++;
            else break;
        end
        chk("dwell_len", 32'(len), 32'd4);
        step();
        chk("dwell_period", 32'(state), 32'd1);
        len = 1; k = 0;
        while (k < 30) begin
            cke = !(k >= 1 && k <= 5);
            step();
            k++;
            if (state == 2'd1) len++;
            else break;
        end
        cke = 1'b1;
        chk("cke_len", 32'(len), 32'd9);

        // Reset in the middle of a hold
        step(); step();
        do_reset();
        chk("rst_hold_state", 32'(state), 32'd0);
        chk("rst_hold_run", 32'(running), 32'd0);
        pulse_start(); step(); step();
        chk("lut_cleared", 32'(state), 32'd0);
        pulse_stop();

        // Inputs seen in the last hold cycle steer the next lookup
        do_reset();
        wr(0, 0, 32'd24);
        wr(1, 0, 32'd7);
        in_p = '0;
        pulse_start();
        step(); step(); step(); step();
        in_p = 1'b1;
        step();
        chk("hold_input_next", 32'(state), 32'd3);
        in_p = '0;
        pulse_stop();
`endif

        // Randomized phase
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst     = ($urandom_range(0, 149) == 0);
            cke     = ($urandom_range(0, 7) != 0);
            start   = ($urandom_range(0, 3) == 0);
            stop    = ($urandom_range(0, 15) == 0);
            in_p    = INPUT_W'($urandom);
            cfg_wen = ($urandom_range(0, 2) == 0);
            addr    = ADDR_W'($urandom);
            sel     = SEL_W'($urandom);
            wdata   = $urandom & 32'h3f;
            step();
        end
        rst = 1'b0; cke = 1'b1; start = 1'b0; stop = 1'b0; cfg_wen = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
